ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 241 ++++++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// -----------------------------------------------------------------------------
// ex_muldiv -- iterative multiply/divide execution unit (RV32M/RV64M funct3 set)
//
// Accepts one request at a time. The multiply path is a radix-2 shift-add
// engine and the divide path is radix-2 restoring division. Both work on
// operand magnitudes and correct the sign of the result as CALC exits.
// Divide by zero and signed overflow bypass CALC and complete right away.
//
// Build option:
//   MULDIV_DIV_EN  defined   -> divide path built in, illegal tied low
//                  undefined -> no divider; ops 4..7 complete immediately
//                               with result 0 and illegal high
//
// Parameters:
//   XLEN   operand/result width (8..64, even)
//   TAG_W  destination-register tag width
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake
//   op                    funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU
//                                 4 DIV 5 DIVU 6 REM 7 REMU
//   rs1_data, rs2_data    operands A and B
//   rd_in / rd_out        destination tag in / tag of the completed op
//   flush                 kill the in-flight op (wins over everything)
//   out_valid / out_ready result handshake
//   result                op result (zero while out_valid is low)
//   illegal               op not supported in this build (with out_valid)
//   PL_stall              high whenever the unit is not idle
// -----------------------------------------------------------------------------
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [TAG_W-1:0] rd_in,
    output logic [TAG_W-1:0] rd_out,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             illegal,
    output logic             PL_stall
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int            CW       = $clog2(XLEN + 1);
    // Counter values 0..XLEN-1 are iteration cycles; XLEN is the sign-fix cycle.
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [TAG_W-1:0]  rd_q, rd_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] prod_q, prod_d;     // {hi, lo}: product or {remainder, quotient}
    logic              neg_q, neg_d;       // final result must be negated
    logic [XLEN-1:0]   res_q, res_d;

    // ---------------------------------------------------------------- decode
    logic            accept;
    logic            a_signed, b_signed, sa, sb, acc_neg;
    logic [XLEN-1:0] mag_a, mag_b;

    assign accept   = in_valid && in_ready;
    // MUL is treated as signed x signed; the low half is the same either way.
    assign a_signed = (!op[2] && (op[1:0] != 2'b11)) || (op[2] && !op[0]);
    assign b_signed = (!op[2] && !op[1]) || (op[2] && !op[0]);
    assign sa       = a_signed && rs1_data[XLEN-1];
    assign sb       = b_signed && rs2_data[XLEN-1];
    assign mag_a    = sa ? (~rs1_data + 1'b1) : rs1_data;
    assign mag_b    = sb ? (~rs2_data + 1'b1) : rs2_data;
    // Remainder takes the dividend's sign; everything else takes the xor.
    assign acc_neg  = (op[2] && op[1]) ? sa : (sa ^ sb);

    // -------------------------------------------------------- multiply step
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step, mul_full;
    logic [XLEN-1:0]   mul_res;

    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    // Multiplier sits in the low half and is consumed LSB first.
    assign mul_step = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]}
                                : {1'b0, prod_q[2*XLEN-1:1]};
    assign mul_full = neg_q ? (~prod_q + 1'b1) : prod_q;
    assign mul_res  = (op_q[1:0] == 2'b00) ? mul_full[XLEN-1:0]
                                           : mul_full[2*XLEN-1:XLEN];

    logic [XLEN-1:0] fix_res;

`ifdef MULDIV_DIV_EN
    // --------------------------------------------------------- divide step
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [XLEN:0]     div_sh, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_step;
    logic [XLEN-1:0]   div_val, div_res;

    // Partial remainder needs one extra bit: after the shift it can reach 2*B-1.
    assign div_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_ge   = div_sh >= {1'b0, opnd_q};
    assign div_step = div_ge ? {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1}
                             : {div_sh[XLEN-1:0],   prod_q[XLEN-2:0], 1'b0};
    assign div_val  = op_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
    assign div_res  = neg_q ? (~div_val + 1'b1) : div_val;
    assign fix_res  = op_q[2] ? div_res : mul_res;
`else
    logic illegal_q, illegal_d;
    assign fix_res  = mul_res;
`endif

    // ------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        opnd_d  = opnd_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        res_d   = res_q;
`ifndef MULDIV_DIV_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = op;
                    rd_d  = rd_in;
                    cnt_d = '0;
                    neg_d = acc_neg;
                    res_d = '0;
`ifndef MULDIV_DIV_EN
                    illegal_d = 1'b0;
`endif
                    if (!op[2]) begin
                        opnd_d  = mag_a;
                        prod_d  = {{XLEN{1'b0}}, mag_b};
                        state_d = ST_CALC;
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (rs2_data == '0) begin
                            // Divide by zero: quotient all ones, remainder = dividend.
                            res_d   = op[1] ? rs1_data : '1;
                            state_d = ST_DONE;
                        end else if (!op[0] && (rs1_data == MIN_NEG) && (rs2_data == '1)) begin
                            // Signed overflow: quotient = dividend, remainder 0.
                            res_d   = op[1] ? '0 : rs1_data;
                            state_d = ST_DONE;
                        end else begin
                            opnd_d  = mag_b;
                            prod_d  = {{XLEN{1'b0}}, mag_a};
                            state_d = ST_CALC;
                        end
`else
                        illegal_d = 1'b1;
                        state_d   = ST_DONE;
`endif
                    end
                end
            end
            ST_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    res_d   = fix_res;
                    state_d = ST_DONE;
                end else begin
`ifdef MULDIV_DIV_EN
                    prod_d = op_q[2] ? div_step : mul_step;
`else
                    prod_d = mul_step;
`endif
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush overrides accept and handshake alike.
        if (flush) begin
            state_d = ST_IDLE;
            res_d   = '0;
        end
    end

    // ---------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            opnd_q  <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
`ifndef MULDIV_DIV_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            opnd_q  <= opnd_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
`ifndef MULDIV_DIV_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // ------------------------------------------------------------ outputs
    assign in_ready  = (state_q == ST_IDLE) && !flush;
    assign out_valid = (state_q == ST_DONE);
    assign PL_stall  = (state_q != ST_IDLE);
    assign result    = out_valid ? res_q : '0;
    assign rd_out    = out_valid ? rd_q : '0;
`ifdef MULDIV_DIV_EN
    assign illegal   = 1'b0;
`else
    assign illegal   = out_valid && illegal_q;
`endif

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed, table-driven bench for ex_muldiv (XLEN=32, TAG_W=5).
// Latency is counted in rising edges after the accept edge: an iterated op
// shows out_valid after XLEN+1 edges; a fast-path op shows it in the cycle
// right after the accept cycle (0 further edges).
module tb_ex_muldiv;

    localparam int XLEN     = 32;
    localparam int TAG_W    = 5;
    localparam int LAT_CALC = XLEN + 1;
    localparam int LAT_FAST = 0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [XLEN-1:0]  rs1_data, rs2_data;
    logic [TAG_W-1:0] rd_in, rd_out;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic             illegal;
    logic             PL_stall;

    ex_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
        .rd_out(rd_out), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .illegal(illegal),
        .PL_stall(PL_stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int l, input logic il);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = l; v.ill = il;
        vecs.push_back(v);
    endtask

    // Issue one request, wait for the result (bounded), then handshake it.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output int lat,
                          output logic ill, output logic [4:0] rdo);
        @(negedge clk);
        in_valid = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_in = rd;
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result; ill = illegal; rdo = rd_out;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_handshake", {62'd0, out_valid, PL_stall}, 64'd0);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic        ill;
        logic [4:0]  rdo;
        int          seen;

        rst_n = 1'b0; in_valid = 1'b0; op = '0; rs1_data = '0; rs2_data = '0;
        rd_in = '0; flush = 1'b0; out_ready = 1'b0;

        // ---------------- reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_result", {32'd0, result}, 64'd0);
        check("reset_rd_out", {59'd0, rd_out}, 64'd0);
        check("reset_illegal", {63'd0, illegal}, 64'd0);
        check("reset_pl_stall", {63'd0, PL_stall}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // ---------------- vector table
        add(3'd0, 32'd3,        32'd5,        32'd15,        LAT_CALC, 1'b0);
        add(3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE,  LAT_CALC, 1'b0);
        add(3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF,  LAT_CALC, 1'b0);
        add(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  LAT_CALC, 1'b0);
        add(3'd1, 32'h80000000, 32'h80000000, 32'h40000000,  LAT_CALC, 1'b0);
        add(3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF,  LAT_CALC, 1'b0);
        add(3'd3, 32'h00010000, 32'h00010000, 32'h00000001,  LAT_CALC, 1'b0);
        add(3'd0, 32'h12345678, 32'd0,        32'd0,         LAT_CALC, 1'b0);
        add(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  LAT_CALC, 1'b0);
        add(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  LAT_CALC, 1'b0);
`ifdef MULDIV_DIV_EN
        add(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  LAT_CALC, 1'b0);
        add(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,  LAT_CALC, 1'b0);
        add(3'd5, 32'd100,      32'd7,        32'd14,        LAT_CALC, 1'b0);
        add(3'd7, 32'd100,      32'd7,        32'd2,         LAT_CALC, 1'b0);
        add(3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD,  LAT_CALC, 1'b0);
        add(3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,         LAT_CALC, 1'b0);
        add(3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,  LAT_CALC, 1'b0);
        add(3'd5, 32'h00001234, 32'd0,        32'hFFFFFFFF,  LAT_FAST, 1'b0);
        add(3'd7, 32'h00001234, 32'd0,        32'h00001234,  LAT_FAST, 1'b0);
        add(3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF,  LAT_FAST, 1'b0);
        add(3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB,  LAT_FAST, 1'b0);
        add(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  LAT_FAST, 1'b0);
        add(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,         LAT_FAST, 1'b0);
`else
        add(3'd4, 32'hFFFFFFF9, 32'd2,        32'd0,         LAT_FAST, 1'b1);
        add(3'd5, 32'd100,      32'd7,        32'd0,         LAT_FAST, 1'b1);
        add(3'd6, 32'hFFFFFFF9, 32'd2,        32'd0,         LAT_FAST, 1'b1);
        add(3'd7, 32'h00001234, 32'd0,        32'd0,         LAT_FAST, 1'b1);
`endif

        foreach (vecs[i]) begin
            logic [4:0] tag;
            tag = 5'(i + 1);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, tag, res, lat, ill, rdo);
            $display("op=%0d a=%h b=%h rd=%0d -> result=%h lat=%0d illegal=%b rd_out=%0d",
                     vecs[i].op, vecs[i].a, vecs[i].b, tag, res, lat, ill, rdo);
            check($sformatf("vec%0d_result", i), {32'd0, res}, {32'd0, vecs[i].exp});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_illegal", i), {63'd0, ill}, {63'd0, vecs[i].ill});
            check($sformatf("vec%0d_rd_out", i), {59'd0, rdo}, {59'd0, tag});
        end

        // ---------------- result held while out_ready is low
        @(negedge clk);
        in_valid = 1'b1; op = 3'd3; rs1_data = 32'hFFFFFFFF; rs2_data = 32'hFFFFFFFF; rd_in = 5'd17;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hold_latency", 64'(lat), 64'(LAT_CALC));
        for (int c = 0; c < 5; c++) begin
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_result", {32'd0, result}, 64'h0FFFFFFFE);
            check("hold_rd_out", {59'd0, rd_out}, 64'd17);
            check("hold_pl_stall", {63'd0, PL_stall}, 64'd1);
            check("hold_in_ready_low", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        $display("hold: MULHU result=%h rd_out=%0d held 5 cycles", result, rd_out);
        @(negedge clk); out_ready = 1'b1;
        check("handshake_in_ready_low", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_handshake_valid", {63'd0, out_valid}, 64'd0);
        check("post_handshake_result", {32'd0, result}, 64'd0);
        check("post_handshake_in_ready", {63'd0, in_ready}, 64'd1);

        // ---------------- flush during CALC with a simultaneous request
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd_in = 5'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("calc_result_zero", {32'd0, result}, 64'd0);
        check("calc_rd_out_zero", {59'd0, rd_out}, 64'd0);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 3'd3; rs1_data = 32'd2; rs2_data = 32'd2; rd_in = 5'd9;
        check("flush_in_ready_low", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_to_idle", {63'd0, PL_stall}, 64'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid || PL_stall) seen++;
            @(posedge clk); #1;
        end
        check("flush_no_activity", 64'(seen), 64'd0);
        $display("flush: in-flight MUL discarded, no accept during flush");
        run_op(3'd0, 32'd6, 32'd7, 5'd21, res, lat, ill, rdo);
        $display("op=0 a=6 b=7 rd=21 -> result=%h lat=%0d rd_out=%0d", res, lat, rdo);
        check("post_flush_result", {32'd0, res}, 64'd42);
        check("post_flush_latency", 64'(lat), 64'(LAT_CALC));
        check("post_flush_rd_out", {59'd0, rdo}, 64'd21);

        // ---------------- asynchronous reset in the middle of CALC
        @(negedge clk);
        in_valid = 1'b1; op = 3'd1; rs1_data = 32'd123; rs2_data = 32'd456; rd_in = 5'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_pl_stall", {63'd0, PL_stall}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("reset_abandons_op", 64'(seen), 64'd0);
        $display("reset: mid-CALC op abandoned");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
